// File: rtl/assoc_cache_pkg.sv
// Shared types and helpers for the two-way set-associative cache.
package cache_pkg;

  // Controller states: lookup, waiting for a line refill, waiting for a write-through.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_t;

  // Tag width left over after removing the set index and the byte offset.
  function automatic int tag_width(input int addr_width, input int set_address_width);
    return addr_width - set_address_width - 2;
  endfunction

  // Line image for the default geometry (32-bit address/data, 8 sets).
  localparam int LINE_DATA_WIDTH = 32;
  localparam int LINE_TAG_WIDTH  = tag_width(32, 3);

  typedef struct packed {
    logic                      valid;
    logic [LINE_TAG_WIDTH-1:0] tag;
    logic [LINE_DATA_WIDTH-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/assoc_cache_way.sv
// One way of the cache: valid/tag/data per set, combinational lookup,
// registered fill (whole line) and byte-merge (write hit) ports.
module cache_way #(
  parameter int DATA_WIDTH        = 32,
  parameter int TAG_WIDTH         = 27,
  parameter int SET_ADDRESS_WIDTH = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [SET_ADDRESS_WIDTH-1:0] idx,
  input  logic                         fill,
  input  logic                         merge,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [TAG_WIDTH-1:0]         wtag,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         valid,
  output logic [TAG_WIDTH-1:0]         tag,
  output logic [DATA_WIDTH-1:0]        data
);

  localparam int SETS  = 2 ** SET_ADDRESS_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;

  logic [SETS-1:0]       valid_r;
  logic [TAG_WIDTH-1:0]  tag_r  [SETS];
  logic [DATA_WIDTH-1:0] data_r [SETS];

  assign valid = valid_r[idx];
  assign tag   = tag_r[idx];
  assign data  = data_r[idx];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r <= '0;
    end else if (fill) begin
      valid_r[idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data storage is never reset; valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_r[idx]  <= wtag;
      data_r[idx] <= wdata;
    end else if (merge) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          data_r[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Two-way set-associative, write-through, no-write-allocate cache with
// per-set LRU and a stall/acknowledge handshake towards main memory.
module assoc_cache #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int SET_ADDRESS_WIDTH = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Req,
  input  logic [DATA_WIDTH/8-1:0] WE,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   WD,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    Stall,
  output logic                    MemReq,
  output logic [DATA_WIDTH/8-1:0] MemWE,
  output logic [ADDR_WIDTH-1:0]   MemA,
  output logic [DATA_WIDTH-1:0]   MemWD,
  input  logic [DATA_WIDTH-1:0]   MemRD,
  input  logic                    MemAck
);
  import cache_pkg::*;

  localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, SET_ADDRESS_WIDTH);
  localparam int SETS      = 2 ** SET_ADDRESS_WIDTH;

  cache_state_t                 state_r;
  logic [SETS-1:0]              lru_r;
  logic [TAG_WIDTH-1:0]         tag_s;
  logic [SET_ADDRESS_WIDTH-1:0] set_s;
  logic                         unused_s;
  logic                         valid0_s, valid1_s;
  logic [TAG_WIDTH-1:0]         tag0_s, tag1_s;
  logic [DATA_WIDTH-1:0]        data0_s, data1_s;
  logic                         hit0_s, hit1_s, hit_s, is_write_s, victim_s;
  logic                         read_hit_s, fill_s, wr_done_s;

  assign tag_s    = A[ADDR_WIDTH-1:SET_ADDRESS_WIDTH+2];
  assign set_s    = A[SET_ADDRESS_WIDTH+1:2];
  assign unused_s = ^A[1:0];

  assign hit0_s     = valid0_s && (tag0_s == tag_s);
  assign hit1_s     = valid1_s && (tag1_s == tag_s);
  assign hit_s      = hit0_s || hit1_s;
  assign is_write_s = |WE;
  // Fill an empty way first; only evict when both are valid.
  assign victim_s   = !valid0_s ? 1'b0 : (!valid1_s ? 1'b1 : lru_r[set_s]);
  assign read_hit_s = (state_r == IDLE) && Req && !is_write_s && hit_s;
  assign fill_s     = (state_r == REFILL) && MemReq && MemAck;
  assign wr_done_s  = (state_r == WRITE) && MemReq && MemAck;

  cache_way #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH), .SET_ADDRESS_WIDTH(SET_ADDRESS_WIDTH)) u_way0 (
    .CLK(CLK), .RST(RST), .idx(set_s),
    .fill(fill_s && !victim_s), .merge(wr_done_s && hit0_s), .be(WE),
    .wtag(tag_s), .wdata(fill_s ? MemRD : WD),
    .valid(valid0_s), .tag(tag0_s), .data(data0_s)
  );

  cache_way #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH), .SET_ADDRESS_WIDTH(SET_ADDRESS_WIDTH)) u_way1 (
    .CLK(CLK), .RST(RST), .idx(set_s),
    .fill(fill_s && victim_s), .merge(wr_done_s && hit1_s), .be(WE),
    .wtag(tag_s), .wdata(fill_s ? MemRD : WD),
    .valid(valid1_s), .tag(tag1_s), .data(data1_s)
  );

  // CPU-side response: read data on a hit, stall while memory is outstanding.
  always_comb begin
    RD    = '0;
    Stall = 1'b0;
    case (state_r)
      IDLE: begin
        if (Req) begin
          if (is_write_s) begin
            Stall = 1'b1;
          end else if (hit_s) begin
            RD = hit0_s ? data0_s : data1_s;
          end else begin
            Stall = 1'b1;
          end
        end else begin
          Stall = 1'b0;
        end
      end
      REFILL:  Stall = 1'b1;
      WRITE:   Stall = !MemAck;
      default: Stall = 1'b0;
    endcase
  end

  // LRU bit names the way not most recently touched in each set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lru_r <= '0;
    end else if (read_hit_s || (wr_done_s && hit_s)) begin
      lru_r[set_s] <= hit0_s;
    end else if (fill_s) begin
      lru_r[set_s] <= !victim_s;
    end else begin
      lru_r <= lru_r;
    end
  end

  // Controller FSM with registered memory-side request outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      MemReq  <= 1'b0;
      MemWE   <= '0;
      MemA    <= '0;
      MemWD   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Req && is_write_s) begin
            state_r <= WRITE;
            MemReq  <= 1'b1;
            MemWE   <= WE;
            MemA    <= {A[ADDR_WIDTH-1:2], 2'b00};
            MemWD   <= WD;
          end else if (Req && !hit_s) begin
            state_r <= REFILL;
            MemReq  <= 1'b1;
            MemWE   <= '0;
            MemA    <= {A[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        REFILL, WRITE: begin
          if (MemAck) begin
            state_r <= IDLE;
            MemReq  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          MemReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: the driver queues expected CPU responses
// and memory transactions; independent monitors pop and compare them.
module tb_assoc_cache;

  logic        CLK, RST, Req, Stall, MemReq, MemAck;
  logic [3:0]  WE, MemWE;
  logic [31:0] A, WD, RD, MemA, MemWD, MemRD;

  typedef struct {
    logic        is_read;
    logic [31:0] rd;
    int          stalls;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] wd;
    string       name;
  } mem_exp_t;

  exp_t     sbq  [$];
  mem_exp_t memq [$];
  int       checks = 0;
  int       errors = 0;
  int       mem_lat;
  logic     force_ack;
  logic [31:0] mem_rdata;

  assoc_cache dut (
    .CLK(CLK), .RST(RST), .Req(Req), .WE(WE), .A(A), .WD(WD), .RD(RD), .Stall(Stall),
    .MemReq(MemReq), .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD), .MemAck(MemAck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges in the mem_lat-th cycle that MemReq is high.
  initial begin
    int cnt;
    cnt = 0;
    MemAck = 1'b0;
    MemRD = 32'h0;
    forever begin
      @(negedge CLK);
      MemRD = mem_rdata;
      if (MemReq) begin
        cnt++;
        MemAck = (cnt == mem_lat);
        if (MemAck) cnt = 0;
      end else begin
        cnt = 0;
        MemAck = force_ack;
      end
    end
  end

  // Monitor: compares CPU acceptances and memory completions against the queues.
  initial begin
    int       stall_cnt;
    exp_t     e;
    mem_exp_t m;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (RST || !Req) begin
        stall_cnt = 0;
      end else if (Stall) begin
        stall_cnt++;
      end else begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got accept at A=%h expected none", A);
        end else begin
          e = sbq.pop_front();
          check32({e.name, "_stalls"}, stall_cnt, e.stalls);
          if (e.is_read) check32({e.name, "_rd"}, RD, e.rd);
        end
        stall_cnt = 0;
      end
      if (MemReq && MemAck) begin
        if (memq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem: got MemA=%h expected no memory access", MemA);
        end else begin
          m = memq.pop_front();
          check32({m.name, "_memwe"}, {28'h0, MemWE}, {28'h0, m.we});
          check32({m.name, "_mema"}, MemA, m.a);
          if (m.we != 4'd0) check32({m.name, "_memwd"}, MemWD, m.wd);
        end
      end
    end
  end

  // Driver: queue expectations, hold the access until Stall drops (bounded).
  task automatic access(input string name, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int stalls,
                        input int lat, input logic [31:0] mrd);
    exp_t     e;
    mem_exp_t m;
    bit       done;
    mem_lat = lat;
    mem_rdata = mrd;
    e.is_read = (we == 4'd0);
    e.rd = rd;
    e.stalls = stalls;
    e.name = name;
    sbq.push_back(e);
    if (stalls > 0) begin
      m.we = we;
      m.a = {a[31:2], 2'b00};
      m.wd = wd;
      m.name = name;
      memq.push_back(m);
    end
    Req = 1'b1;
    WE = we;
    A = a;
    WD = wd;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      #2;
      if (!Stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got Stall stuck high expected release within 50 cycles", name);
    end
    @(posedge CLK);
    #1;
    Req = 1'b0;
    WE = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    bit seen;
    Req = 1'b0; WE = 4'd0; A = 32'h0; WD = 32'h0;
    force_ack = 1'b0; mem_lat = 1; mem_rdata = 32'h0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #2;
    check32("rst_memreq", {31'h0, MemReq}, 32'h0);
    check32("rst_memwe", {28'h0, MemWE}, 32'h0);
    check32("rst_mema", MemA, 32'h0);
    check32("rst_memwd", MemWD, 32'h0);
    check32("rst_rd", RD, 32'h0);
    check32("rst_stall", {31'h0, Stall}, 32'h0);
    @(posedge CLK);
    #1;

    // Miss with 3-cycle memory, then hit.
    access("rd10_miss",  4'd0, 32'h10,  32'h0, 32'hDEADBEEF, 4, 3, 32'hDEADBEEF);
    access("rd10_hit",   4'd0, 32'h10,  32'h0, 32'hDEADBEEF, 0, 1, 32'h0);
    // Second line in set 4 goes to way1; LRU then picks the 0x110 way.
    access("rd110_miss", 4'd0, 32'h110, 32'h0, 32'h11110110, 2, 1, 32'h11110110);
    access("rd10_hit2",  4'd0, 32'h10,  32'h0, 32'hDEADBEEF, 0, 1, 32'h0);
    access("rd210_miss", 4'd0, 32'h210, 32'h0, 32'h22220210, 3, 2, 32'h22220210);
    access("rd10_hit3",  4'd0, 32'h10,  32'h0, 32'hDEADBEEF, 0, 1, 32'h0);
    access("rd110_evct", 4'd0, 32'h110, 32'h0, 32'h33330110, 2, 1, 32'h33330110);
    // Write hit merges low bytes.
    access("wr10_hit",   4'b0011, 32'h10, 32'h0000CAFE, 32'h0, 2, 2, 32'h0);
    access("rd10_merge", 4'd0, 32'h10,  32'h0, 32'hDEADCAFE, 0, 1, 32'h0);
    // Write miss allocates nothing.
    access("wr400_miss", 4'b1111, 32'h400, 32'h12345678, 32'h0, 3, 3, 32'h0);
    access("rd400_miss", 4'd0, 32'h400, 32'h0, 32'h12345678, 2, 1, 32'h12345678);

    // Reset during a refill.
    mem_lat = 20;
    Req = 1'b1; WE = 4'd0; A = 32'h500;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      #2;
      if (MemReq) seen = 1'b1;
    end
    check32("abort_memreq_seen", {31'h0, seen}, 32'h1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    Req = 1'b0;
    #1;
    check32("abort_memreq_drop", {31'h0, MemReq}, 32'h0);
    check32("abort_stall", {31'h0, Stall}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    force_ack = 1'b1;
    @(negedge CLK);
    #2;
    check32("stray_ack_memreq", {31'h0, MemReq}, 32'h0);
    check32("stray_ack_stall", {31'h0, Stall}, 32'h0);
    force_ack = 1'b0;
    @(negedge CLK);
    #2;
    check32("stray_ack_after", {31'h0, MemReq}, 32'h0);
    @(posedge CLK);
    #1;
    access("rd500_miss", 4'd0, 32'h500, 32'h0, 32'h55555555, 3, 2, 32'h55555555);
    access("rd10_postrst", 4'd0, 32'h10, 32'h0, 32'h0BADF00D, 2, 1, 32'h0BADF00D);

    repeat (3) @(negedge CLK);
    check32("sb_empty", sbq.size(), 32'h0);
    check32("memq_empty", memq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Two-way set-associative, write-through, no-write-allocate data cache with LRU replacement. It sits between the core's memory stage and data memory. It adds a stall/handshake interface so miss latency can vary, which makes it usable with multi-cycle main memory. Set count and word/address widths are parametrised; each line is one word with per-byte write enables.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 32, byte address width
- SET_ADDRESS_WIDTH, 3, log2(sets per way)
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- Req  input  1  CPU access valid; held stable with A/WE/WD while Stall=1
- WE  input  DATA_WIDTH/8  byte write enables; 0 = read, nonzero = write
- A  input  ADDR_WIDTH  byte address; bits [1:0] ignored for lookup
- WD  input  DATA_WIDTH  write data
- RD  output  DATA_WIDTH  read data, valid when Req & ~|WE & ~Stall
- Stall  output  1  CPU must hold the current access
- MemReq  output  1  memory request, registered
- MemWE  output  DATA_WIDTH/8  memory byte enables, registered
- MemA  output  ADDR_WIDTH  word-aligned memory address, registered
- MemWD  output  DATA_WIDTH  memory write data, registered
- MemRD  input  DATA_WIDTH  memory read data, valid with MemAck
- MemAck  input  1  memory completion; counts only while MemReq=1

## Operation
- Address split: tag = A[ADDR_WIDTH-1 : SET_ADDRESS_WIDTH+2], set = A[SET_ADDRESS_WIDTH+1 : 2]. TAG_WIDTH = ADDR_WIDTH-SET_ADDRESS_WIDTH-2.
- Per set and way: valid bit, tag, and data word. Per set: one LRU bit naming the victim way.
- Hit: the way is valid and its tag is equal to the lookup tag. Both ways hitting is impossible by construction.
- State machine states: IDLE, REFILL, WRITE.
- IDLE, Req=0: Stall=0. No state change.
- IDLE, read hit: RD is the hitting word, combinational. Stall=0. LRU is set to the other way.
- IDLE, read miss: Stall=1. Go to REFILL. Register MemReq=1, MemWE=0, MemA={A[ADDR_WIDTH-1:2],2'b00}.
- IDLE, write (any hit state): Stall=1. Go to WRITE. Register MemReq=1, MemWE=WE, MemA as above, MemWD=WD.
- REFILL: Stall=1. When MemAck=1:
  - choose the victim: way0 if invalid, else way1 if invalid, else the LRU way;
  - write valid, tag and MemRD into the victim;
  - set LRU to the other way;
  - clear MemReq and go to IDLE.
  - The held read then hits on the next cycle.
- WRITE: Stall = ~MemAck. When MemAck=1:
  - if the access hits, merge enabled bytes of WD into the hitting way and set LRU to the other way;
  - on a miss, allocate nothing;
  - clear MemReq and go to IDLE.
  - The CPU advances on this edge.
- MemAck while MemReq=0 is ignored.

## Timing
- Reset values: all valid bits 0, all LRU bits 0, state IDLE, MemReq 0, MemWE 0, MemA 0, MemWD 0. RD and Stall are combinational; with Req=0 both are 0.
- Read hit: 0-cycle latency, no stall.
- Read miss detected in cycle 0:
  - MemReq=1 from cycle 1;
  - MemAck in cycle k≥1 fills the line at the end of cycle k;
  - hit with Stall=0 in cycle k+1;
  - total stall is k+1 cycles.
- Write detected in cycle 0: MemReq=1 from cycle 1, MemAck in cycle k, and Stall=0 in cycle k.
- MemReq falls in the cycle after MemAck. Back-to-back requests therefore have at least one IDLE cycle between them.
- RST mid-REFILL or mid-WRITE: immediate abandon. MemReq drops asynchronously and no line is written.
- Data storage contents are not reset. Valid bits gate all use of them.

## Structure
- Package cache_pkg holds:
  - state enum cache_state_t {IDLE, REFILL, WRITE};
  - localparam helper for TAG_WIDTH;
  - typedef of the line struct {valid, tag, data}.
- Sub-module cache_way: one way's storage, 2**SET_ADDRESS_WIDTH lines.
  - Provides a combinational read port and a registered fill/byte-merge write port.
  - Outputs per-way valid, tag and data for the looked-up set.
  - assoc_cache instantiates two.
- Top level holds the FSM, the hit/victim logic, the LRU array and the memory-side registers.

## Test plan
- Reset, then read A=0x00000010 with a 3-cycle memory (MemAck in the third MemReq cycle, MemRD=0xDEADBEEF): Stall high for 4 cycles, then RD=0xDEADBEEF; a repeat read hits with no MemReq.
- Fill 0x00000010 and 0x00000110 (same set, different tags), read 0x00000010, then miss on 0x00000210: way holding 0x110 is evicted; re-read of 0x10 hits, 0x110 misses.
- Write WE=4'b0011, WD=0x0000CAFE to cached 0x10: MemWE=0011, MemWD=0x0000CAFE; after MemAck, read returns 0xDEADCAFE with no memory access.
- Write to uncached 0x00000400, then read it: write goes to memory only; the following read misses and refills.
- Assert RST during REFILL: MemReq falls the same cycle, a subsequent read of that address misses, and a stray MemAck while idle leaves state unchanged.
